// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: hazard-source inputs toward the controller and pipeline
// control, status and performance outputs back from it.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_rt;
  logic             ex_mem_read;
  logic             branch_taken;
  logic             jump_id;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_flush;
  logic             id_ex_flush;
  logic             hold_all;
  logic             mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, branch_taken, jump_id, mem_busy,
    input  pc_write, if_id_write, if_flush, id_ex_flush, hold_all, mem_err, state,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, branch_taken, jump_id, mem_busy,
    output pc_write, if_id_write, if_flush, id_ex_flush, hold_all, mem_err, state,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID write enables, flushes and global hold.
// Performance counters are built only when HAZ_PERF_CNT_EN is defined, else tied to 0.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 15,
  parameter int unsigned CNT_W             = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StMemWait   = 2'd2,
    StError     = 2'd3
  } state_e;

  localparam logic [2:0] StallReload = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] WaitLimit   = 8'(MEM_TIMEOUT);
  localparam bit         MultiStall  = (LOAD_STALL_CYCLES > 1);

  state_e     state_q, state_d;
  logic [2:0] left_q, left_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
  logic       lu;
  logic       pc_write, if_id_write, if_flush, id_ex_flush, hold_all;

  assign lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
              ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    wait_d      = wait_q;
    err_d       = err_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_flush    = 1'b0;
    id_ex_flush = 1'b0;
    hold_all    = 1'b0;
    if (state_q == StError) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      hold_all    = 1'b1;
    end else if (hz.mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      hold_all    = 1'b1;
      if (state_q == StMemWait) begin
        if (wait_q == WaitLimit) begin
          state_d = StError;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end else begin
        // Entering from RUN or LOAD_STALL; leftover stall cycles are dropped.
        state_d = StMemWait;
        wait_d  = 8'd1;
      end
    end else if (state_q == StLoadStall) begin
      // EX holds our own bubble here, so branch_taken cannot be genuine.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      left_d      = left_q - 3'd1;
      if (left_q == 3'd1) begin
        state_d = StRun;
      end
    end else begin
      // RUN, or a MEM_WAIT cycle whose memory has just become ready.
      state_d = StRun;
      if (hz.branch_taken) begin
        if_flush    = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        if (MultiStall) begin
          state_d = StLoadStall;
          left_d  = StallReload;
        end
      end else if (hz.jump_id) begin
        if_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      left_q  <= 3'd0;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign hz.pc_write    = pc_write & ~reset;
  assign hz.if_id_write = if_id_write & ~reset;
  assign hz.if_flush    = if_flush & ~reset;
  assign hz.id_ex_flush = id_ex_flush & ~reset;
  assign hz.hold_all    = hold_all & ~reset;
  assign hz.mem_err     = err_q;
  assign hz.state       = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (if_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
`else
  assign hz.stall_count = {CNT_W{1'b0}};
  assign hz.flush_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations share random stimulus and are checked each
// cycle against an action-level model, plus directed scenarios with literal expectations.
module tb_hazard_ctrl;
  localparam int unsigned LscA = 1;
  localparam int unsigned TmoA = 15;
  localparam int unsigned CwA  = 16;
  localparam int unsigned LscB = 3;
  localparam int unsigned TmoB = 4;
  localparam int unsigned CwB  = 4;
`ifdef HAZ_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  localparam int ModeRun = 0, ModeStall = 1, ModeWait = 2, ModeErr = 3;
  localparam int ActNorm = 0, ActHold = 1, ActBubble = 2, ActSquash = 3, ActJump = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;
  logic       jump_id = 1'b0, mem_busy = 1'b0;

  hazard_ctrl_if #(.CNT_W(CwA)) hz_a ();
  hazard_ctrl_if #(.CNT_W(CwB)) hz_b ();

  hazard_ctrl #(.LOAD_STALL_CYCLES(LscA), .MEM_TIMEOUT(TmoA), .CNT_W(CwA)) u_dut_a (
    .clk(clk), .reset(reset), .hz(hz_a)
  );
  hazard_ctrl #(.LOAD_STALL_CYCLES(LscB), .MEM_TIMEOUT(TmoB), .CNT_W(CwB)) u_dut_b (
    .clk(clk), .reset(reset), .hz(hz_b)
  );

  assign hz_a.id_rs = id_rs;               assign hz_b.id_rs = id_rs;
  assign hz_a.id_rt = id_rt;               assign hz_b.id_rt = id_rt;
  assign hz_a.id_uses_rt = id_uses_rt;     assign hz_b.id_uses_rt = id_uses_rt;
  assign hz_a.ex_rt = ex_rt;               assign hz_b.ex_rt = ex_rt;
  assign hz_a.ex_mem_read = ex_mem_read;   assign hz_b.ex_mem_read = ex_mem_read;
  assign hz_a.branch_taken = branch_taken; assign hz_b.branch_taken = branch_taken;
  assign hz_a.jump_id = jump_id;           assign hz_b.jump_id = jump_id;
  assign hz_a.mem_busy = mem_busy;         assign hz_b.mem_busy = mem_busy;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int m_mode[2] = '{0, 0};
  int m_left[2] = '{0, 0};
  int m_wait[2] = '{0, 0};
  int m_sc[2] = '{0, 0};
  int m_fc[2] = '{0, 0};

  function automatic int lsc_of(input int k);
    return (k == 0) ? int'(LscA) : int'(LscB);
  endfunction
  function automatic int tmo_of(input int k);
    return (k == 0) ? int'(TmoA) : int'(TmoB);
  endfunction
  function automatic int cmax_of(input int k);
    return (k == 0) ? ((1 << CwA) - 1) : ((1 << CwB) - 1);
  endfunction

  function automatic logic lu_now();
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  // Which pipeline action the priority rules select for a given model mode.
  function automatic int action(input int mode);
    if (mode == ModeErr || mem_busy) return ActHold;
    if (mode == ModeStall) return ActBubble;
    if (branch_taken) return ActSquash;
    if (lu_now()) return ActBubble;
    if (jump_id) return ActJump;
    return ActNorm;
  endfunction

  // {pc_write, if_id_write, if_flush, id_ex_flush, hold_all}
  function automatic logic [4:0] ctl_of(input int act);
    case (act)
      ActHold:   return 5'b00001;
      ActBubble: return 5'b00010;
      ActSquash: return 5'b11110;
      ActJump:   return 5'b11100;
      default:   return 5'b11000;
    endcase
  endfunction

  function automatic logic stalls(input int mode);
    return (action(mode) == ActHold) || (action(mode) == ActBubble);
  endfunction
  function automatic logic flushes(input int mode);
    return (action(mode) == ActSquash) || (action(mode) == ActJump);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] <= ModeRun;
        m_left[k] <= 0;
        m_wait[k] <= 0;
        m_sc[k]   <= 0;
        m_fc[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (stalls(m_mode[k]) && m_sc[k] < cmax_of(k)) m_sc[k] <= m_sc[k] + 1;
        if (flushes(m_mode[k]) && m_fc[k] < cmax_of(k)) m_fc[k] <= m_fc[k] + 1;
        if (m_mode[k] == ModeErr) begin
          m_mode[k] <= ModeErr;
        end else if (mem_busy) begin
          if (m_mode[k] != ModeWait) begin
            m_mode[k] <= ModeWait;
            m_wait[k] <= 1;
          end else if (m_wait[k] >= tmo_of(k)) begin
            m_mode[k] <= ModeErr;
          end else begin
            m_wait[k] <= m_wait[k] + 1;
          end
        end else if (m_mode[k] == ModeStall) begin
          m_left[k] <= m_left[k] - 1;
          if (m_left[k] == 1) m_mode[k] <= ModeRun;
        end else if (action(m_mode[k]) == ActBubble && lsc_of(k) > 1) begin
          m_mode[k] <= ModeStall;
          m_left[k] <= lsc_of(k) - 1;
        end else begin
          m_mode[k] <= ModeRun;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic compare_cycle();
    logic [4:0] want_a, want_b;
    want_a = reset ? 5'b0 : ctl_of(action(m_mode[0]));
    want_b = reset ? 5'b0 : ctl_of(action(m_mode[1]));
    chk("a_ctl", int'({hz_a.pc_write, hz_a.if_id_write, hz_a.if_flush, hz_a.id_ex_flush,
                       hz_a.hold_all}), int'(want_a));
    chk("b_ctl", int'({hz_b.pc_write, hz_b.if_id_write, hz_b.if_flush, hz_b.id_ex_flush,
                       hz_b.hold_all}), int'(want_b));
    chk("a_state", int'(hz_a.state), m_mode[0]);
    chk("b_state", int'(hz_b.state), m_mode[1]);
    chk("a_mem_err", int'(hz_a.mem_err), int'(m_mode[0] == ModeErr));
    chk("b_mem_err", int'(hz_b.mem_err), int'(m_mode[1] == ModeErr));
    chk("a_stall_count", int'(hz_a.stall_count), Perf ? m_sc[0] : 0);
    chk("b_stall_count", int'(hz_b.stall_count), Perf ? m_sc[1] : 0);
    chk("a_flush_count", int'(hz_a.flush_count), Perf ? m_fc[0] : 0);
    chk("b_flush_count", int'(hz_b.flush_count), Perf ? m_fc[1] : 0);
  endtask

  // Checks the cycle at the falling edge, then returns 1 time unit after the next rise.
  task automatic cyc();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; jump_id = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    #2;
    chk("rst_a_state", int'(hz_a.state), 0);
    chk("rst_a_pc_write", int'(hz_a.pc_write), 0);
    chk("rst_b_if_id_write", int'(hz_b.if_id_write), 0);
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #1;
    // Load-use on rs with a single bubble.
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #2;
    chk("s1_pc_write", int'(hz_a.pc_write), 0);
    chk("s1_if_id_write", int'(hz_a.if_id_write), 0);
    chk("s1_id_ex_flush", int'(hz_a.id_ex_flush), 1);
    cyc();
    ex_mem_read = 1'b0;
    #2;
    chk("s1_pc_write_after", int'(hz_a.pc_write), 1);
    chk("s1_stall_count", int'(hz_a.stall_count), Perf ? 1 : 0);
    cyc();

    // Register 0 and unused rt never stall.
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #2;
    chk("s2_r0_pc_write", int'(hz_a.pc_write), 1);
    cyc();
    ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0; id_rs = 5'd3;
    #2;
    chk("s2_rt_unused_pc_write", int'(hz_a.pc_write), 1);
    chk("s2_rt_unused_b_pc_write", int'(hz_b.pc_write), 1);
    cyc();

    // Taken branch beats load-use and jump.
    do_reset();
    branch_taken = 1'b1; jump_id = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #2;
    chk("s3_if_flush", int'(hz_a.if_flush), 1);
    chk("s3_id_ex_flush", int'(hz_a.id_ex_flush), 1);
    chk("s3_pc_write", int'(hz_a.pc_write), 1);
    cyc();
    clear_inputs();
    #2;
    chk("s3_flush_count", int'(hz_a.flush_count), Perf ? 1 : 0);
    chk("s3_state", int'(hz_a.state), 0);
    cyc();

    // Multi-cycle stall preempted by memory wait (config b, 3 bubbles).
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    cyc();
    clear_inputs();
    mem_busy = 1'b1;
    #2;
    chk("s4_stall_state", int'(hz_b.state), 1);
    chk("s4_hold", int'(hz_b.hold_all), 1);
    cyc();
    #2;
    chk("s4_wait_state", int'(hz_b.state), 2);
    mem_busy = 1'b0;
    #1;
    chk("s4_release_pc_write", int'(hz_b.pc_write), 1);
    chk("s4_release_id_ex_flush", int'(hz_b.id_ex_flush), 0);
    cyc();
    #2;
    chk("s4_run_state", int'(hz_b.state), 0);
    cyc();

    // Memory timeout (config b, limit 4) and reset out of ERROR.
    do_reset();
    mem_busy = 1'b1;
    #2;
    chk("s5_first_hold", int'(hz_b.hold_all), 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("s5_wait_state", int'(hz_b.state), 2);
      cyc();
    end
    #2;
    chk("s5_err_state", int'(hz_b.state), 3);
    chk("s5_mem_err", int'(hz_b.mem_err), 1);
    mem_busy = 1'b0;
    cyc();
    #2;
    chk("s5_err_sticky", int'(hz_b.state), 3);
    reset = 1'b1;
    #1;
    chk("s5_reset_state", int'(hz_b.state), 0);
    chk("s5_reset_mem_err", int'(hz_b.mem_err), 0);
    cyc();
    reset = 1'b0;

    // Random traffic, each segment with its own memory-busy density.
    for (int seg = 0; seg < 30; seg++) begin
      int busy_pct;
      busy_pct = ($urandom_range(0, 2) == 0) ? 85 : 10;
      for (int i = 0; i < 50; i++) begin
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        ex_rt = 5'($urandom_range(0, 3));
        id_uses_rt = 1'($urandom_range(0, 1));
        ex_mem_read = ($urandom_range(0, 99) < 40);
        branch_taken = ($urandom_range(0, 99) < 15);
        jump_id = ($urandom_range(0, 99) < 15);
        mem_busy = ($urandom_range(0, 99) < busy_pct);
        if (i == 0 || $urandom_range(0, 59) == 0) begin
          #2;
          reset = 1'b1;
        end
        cyc();
        reset = 1'b0;
      end
    end
    clear_inputs();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
